// File: rtl/bus_pkg.sv
// Shared core data-bus definitions used by every memory-mapped slave.
package bus_pkg;

    // Transfer size encoding carried on the tsize lines (2'b11 is reserved).
    typedef enum logic [1:0] {
        TSIZE_BYTE = 2'b00,
        TSIZE_HALF = 2'b01,
        TSIZE_WORD = 2'b10
    } tsize_t;

    // Address nibble addr[31:28] that the top-level dbus mux routes to the UART.
    localparam logic [3:0] UART_BASE = 4'h1;

endpackage

// File: rtl/uart_pkg.sv
// UART register map, status bit positions and serial state encodings.
package uart_pkg;

    // Register offsets within the UART window (addr[3:0]).
    localparam logic [3:0] REG_TXDATA  = 4'h0;
    localparam logic [3:0] REG_RXDATA  = 4'h4;
    localparam logic [3:0] REG_STATUS  = 4'h8;
    localparam logic [3:0] REG_DIVISOR = 4'hC;

    // Bit positions inside the STATUS word.
    localparam int STAT_TX_EMPTY   = 0;
    localparam int STAT_TX_FULL    = 1;
    localparam int STAT_TX_BUSY    = 2;
    localparam int STAT_RX_VALID   = 3;
    localparam int STAT_RX_OVERRUN = 4;

    // Transmit frame sequencer states.
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // Receive frame sequencer states.
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO feeding the UART transmitter.
// Pointers carry one extra wrap bit so full and empty can be told apart
// without a separate occupancy counter. A push while full is accepted only
// when a pop frees a slot in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Advance the read/write pointers; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_slave.sv
// Memory-mapped UART peripheral: bus register file, programmable baud
// divisor, TX frame sequencer fed by a small FIFO and an RX frame sequencer
// with a single holding register. Every bus transfer completes with a fixed
// one-cycle latency; erroneous transfers leave all state untouched.
module uart_slave
    import bus_pkg::*;
    import uart_pkg::*;
#(
    parameter int          TX_DEPTH  = 8,
    parameter int unsigned DIV_RESET = 868,
    parameter int          DIV_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ss,
    input  logic        bstart,
    input  logic        bwrite,
    input  logic [31:0] addr,
    input  logic [1:0]  tsize,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        bdone,
    output logic        berror,
    output logic        uart_tx,
    input  logic        uart_rx
);

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

    // Bus decode results
    logic        xfer;
    logic        bus_err;
    logic [31:0] rd_val;
    logic        fifo_push;
    logic        rxdata_rd;
    logic        status_rd;
    logic        div_wr;
    logic [31:0] status_word;

    // Baud divisor
    logic [DIV_W-1:0] divisor;
    logic [DIV_W-1:0] div_m1;
    logic [DIV_W-1:0] half_m1;
    logic [DIV_W-1:0] div_new;

    // TX path
    tx_state_t        tx_state;
    logic [DIV_W-1:0] tx_cnt;
    logic [7:0]       tx_shift;
    logic [2:0]       tx_bit_idx;
    logic             tx_pop;
    logic             tx_busy;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;

    // RX path
    rx_state_t        rx_state;
    logic [DIV_W-1:0] rx_cnt;
    logic [7:0]       rx_shift;
    logic [2:0]       rx_bit_idx;
    logic             rx_s1;
    logic             rx_s2;
    logic             rx_s3;
    logic             rx_fall;
    logic             rx_frame_ok;
    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_overrun;

    // Upper address bits are decoded by the dbus mux; wdata is only partly used.
    logic unused_bits;
    assign unused_bits = ^{addr[31:4], wdata};

    assign xfer    = ss && bstart;
    assign div_m1  = divisor - DIV_ONE;
    assign half_m1 = (divisor >> 1) - DIV_ONE;
    assign div_new = (wdata[DIV_W-1:0] < DIV_MIN) ? DIV_MIN : wdata[DIV_W-1:0];
    assign tx_busy = (tx_state != TX_IDLE);
    assign tx_pop  = !fifo_empty &&
                     ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && (tx_cnt == '0)));
    assign rx_fall = rx_s3 && !rx_s2;
    assign rx_frame_ok = (rx_state == RX_STOP) && (rx_cnt == '0) && rx_s2;

    // Assemble the STATUS word from the live flags.
    always_comb begin
        status_word                  = '0;
        status_word[STAT_TX_EMPTY]   = fifo_empty;
        status_word[STAT_TX_FULL]    = fifo_full;
        status_word[STAT_TX_BUSY]    = tx_busy;
        status_word[STAT_RX_VALID]   = rx_valid;
        status_word[STAT_RX_OVERRUN] = rx_overrun;
    end

    // Decode the current transfer into read data, an error flag and side-effect strobes.
    always_comb begin
        bus_err   = 1'b0;
        rd_val    = '0;
        fifo_push = 1'b0;
        rxdata_rd = 1'b0;
        status_rd = 1'b0;
        div_wr    = 1'b0;
        if (xfer) begin
            if (addr[1:0] != 2'b00) begin
                bus_err = 1'b1;
            end else begin
                case (addr[3:0])
                    REG_TXDATA: begin
                        if (!bwrite)                     bus_err   = 1'b1;
                        else if (fifo_full && !tx_pop)   bus_err   = 1'b1;
                        else                             fifo_push = 1'b1;
                    end
                    REG_RXDATA: begin
                        if (bwrite) begin
                            bus_err = 1'b1;
                        end else begin
                            rxdata_rd = 1'b1;
                            rd_val    = rx_valid ? {24'b0, rx_byte} : 32'b0;
                        end
                    end
                    REG_STATUS: begin
                        if (bwrite) begin
                            bus_err = 1'b1;
                        end else begin
                            status_rd = 1'b1;
                            rd_val    = status_word;
                        end
                    end
                    REG_DIVISOR: begin
                        if (tsize != TSIZE_WORD) bus_err = 1'b1;
                        else if (bwrite)         div_wr  = 1'b1;
                        else                     rd_val  = 32'(divisor);
                    end
                    default: bus_err = 1'b1;
                endcase
            end
        end
    end

    // Register the bus response so it appears exactly one cycle after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            bdone  <= 1'b0;
            berror <= 1'b0;
            rdata  <= '0;
        end else begin
            bdone  <= xfer;
            berror <= xfer && bus_err;
            rdata  <= rd_val;
        end
    end

    // Baud divisor register; values below 2 are clamped so half-bit timing stays valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            divisor <= DIV_W'(DIV_RESET);
        end else if (div_wr) begin
            divisor <= div_new;
        end
    end

    uart_tx_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (tx_pop),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // TX frame sequencer: start bit, eight data bits LSB first, stop bit, chaining frames without a gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state   <= TX_IDLE;
            tx_cnt     <= '0;
            tx_shift   <= '0;
            tx_bit_idx <= '0;
            uart_tx    <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_shift <= fifo_dout;
                        tx_cnt   <= div_m1;
                        tx_state <= TX_START;
                        uart_tx  <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt == '0) begin
                        tx_state   <= TX_DATA;
                        tx_cnt     <= div_m1;
                        tx_bit_idx <= '0;
                        uart_tx    <= tx_shift[0];
                        tx_shift   <= {1'b0, tx_shift[7:1]};
                    end else begin
                        tx_cnt <= tx_cnt - DIV_ONE;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= div_m1;
                        if (tx_bit_idx == 3'd7) begin
                            tx_state <= TX_STOP;
                            uart_tx  <= 1'b1;
                        end else begin
                            tx_bit_idx <= tx_bit_idx + 3'd1;
                            uart_tx    <= tx_shift[0];
                            tx_shift   <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt - DIV_ONE;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == '0) begin
                        if (tx_pop) begin
                            tx_shift <= fifo_dout;
                            tx_cnt   <= div_m1;
                            tx_state <= TX_START;
                            uart_tx  <= 1'b0;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - DIV_ONE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous RX line plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // RX frame sequencer: mid-bit sampling, start-glitch rejection, stop-bit validation.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_shift   <= '0;
            rx_bit_idx <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_state <= RX_START;
                        rx_cnt   <= half_m1;
                    end
                end
                RX_START: begin
                    if (rx_cnt == '0) begin
                        if (rx_s2) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state   <= RX_DATA;
                            rx_cnt     <= div_m1;
                            rx_bit_idx <= '0;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - DIV_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_cnt   <= div_m1;
                        if (rx_bit_idx == 3'd7) rx_state   <= RX_STOP;
                        else                    rx_bit_idx <= rx_bit_idx + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - DIV_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == '0) rx_state <= RX_IDLE;
                    else              rx_cnt   <= rx_cnt - DIV_ONE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // RX holding register and flags; a completing frame overrides a same-cycle RXDATA read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (rxdata_rd) rx_valid   <= 1'b0;
            if (status_rd) rx_overrun <= 1'b0;
            if (rx_frame_ok) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
                if (rx_valid && !rxdata_rd) rx_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_slave.sv
// Directed self-checking bench for uart_slave: register access, TX waveform,
// FIFO full handling, mid-frame reset, RX loopback with overrun, and error decode.
module tb_uart_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        ss;
    logic        bstart;
    logic        bwrite;
    logic [31:0] addr;
    logic [1:0]  tsize;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        bdone;
    logic        berror;
    logic        uart_tx;
    wire         uart_rx;
    logic        loopback;
    logic        rx_drive;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    assign uart_rx = loopback ? uart_tx : rx_drive;

    uart_slave dut (
        .clk     (clk),
        .rst     (rst),
        .ss      (ss),
        .bstart  (bstart),
        .bwrite  (bwrite),
        .addr    (addr),
        .tsize   (tsize),
        .wdata   (wdata),
        .rdata   (rdata),
        .bdone   (bdone),
        .berror  (berror),
        .uart_tx (uart_tx),
        .uart_rx (uart_rx)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One bus transfer: drive on a falling edge, sample the response one cycle later.
    task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                                 input logic [31:0] wd, output logic [31:0] rd,
                                 output logic err, output logic done);
        @(negedge clk);
        ss = 1'b1; bstart = 1'b1; bwrite = wr; addr = a; tsize = sz; wdata = wd;
        @(negedge clk);
        rd = rdata; err = berror; done = bdone;
        ss = 1'b0; bstart = 1'b0;
    endtask

    task automatic busCheck(input string tag, input logic wr, input logic [31:0] a,
                            input logic [1:0] sz, input logic [31:0] wd,
                            input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        err;
        logic        done;
        applyStimulus(wr, a, sz, wd, rd, err, done);
        checkOutput({tag, "_bdone"}, 32'(done), 32'd1);
        checkOutput({tag, "_berror"}, 32'(err), 32'(exp_err));
        checkOutput({tag, "_rdata"}, rd, exp_rd);
    endtask

    initial begin
        logic [9:0]  frame;
        logic [39:0] samples;
        logic        found;
        rst = 1'b1; ss = 1'b0; bstart = 1'b0; bwrite = 1'b0;
        addr = '0; tsize = SZ_WORD; wdata = '0;
        loopback = 1'b0; rx_drive = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_uart_tx", 32'(uart_tx), 32'd1);
        checkOutput("reset_bdone", 32'(bdone), 32'd0);
        rst = 1'b0;
        busCheck("status_after_reset", 1'b0, 32'h1000_0008, SZ_WORD, 0, 32'h1, 1'b0);
        busCheck("divisor_after_reset", 1'b0, 32'h1000_000C, SZ_WORD, 0, 32'd868, 1'b0);
        busCheck("rxdata_empty", 1'b0, 32'h1000_0004, SZ_WORD, 0, 32'h0, 1'b0);

        // Divisor clamp
        busCheck("div_wr_1", 1'b1, 32'h1000_000C, SZ_WORD, 32'd1, 32'h0, 1'b0);
        busCheck("div_rd_clamp1", 1'b0, 32'h1000_000C, SZ_WORD, 0, 32'd2, 1'b0);
        busCheck("div_wr_0", 1'b1, 32'h1000_000C, SZ_WORD, 32'd0, 32'h0, 1'b0);
        busCheck("div_rd_clamp0", 1'b0, 32'h1000_000C, SZ_WORD, 0, 32'd2, 1'b0);

        // TX waveform of 8'hA5 at divisor 4
        busCheck("div_wr_4", 1'b1, 32'h1000_000C, SZ_WORD, 32'd4, 32'h0, 1'b0);
        busCheck("tx_push_a5", 1'b1, 32'h1000_0000, SZ_BYTE, 32'hA5, 32'h0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (uart_tx == 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("tx_start_seen", 32'(found), 32'd1);
        samples[0] = uart_tx;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            samples[k] = uart_tx;
        end
        frame = {1'b1, 8'hA5, 1'b0};
        for (int j = 0; j < 10; j++) begin
            checkOutput($sformatf("tx_bit%0d", j), 32'(samples[4*j +: 4]), 32'({4{frame[j]}}));
        end
        @(negedge clk);
        checkOutput("tx_idle_after_frame", 32'(uart_tx), 32'd1);
        busCheck("status_tx_done", 1'b0, 32'h1000_0008, SZ_WORD, 0, 32'h1, 1'b0);

        // Fill the FIFO back-to-back at divisor 100
        busCheck("div_wr_100", 1'b1, 32'h1000_000C, SZ_WORD, 32'd100, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checkOutput($sformatf("fill%0d_bdone", i - 1), 32'(bdone), 32'd1);
                checkOutput($sformatf("fill%0d_berror", i - 1), 32'(berror), 32'd0);
            end
            ss = 1'b1; bstart = 1'b1; bwrite = 1'b1; addr = 32'h1000_0000;
            tsize = SZ_BYTE; wdata = 32'(8'h10 + i);
        end
        @(negedge clk);
        checkOutput("fill9_bdone", 32'(bdone), 32'd1);
        checkOutput("fill9_berror", 32'(berror), 32'd1);
        ss = 1'b0; bstart = 1'b0;
        busCheck("status_full", 1'b0, 32'h1000_0008, SZ_WORD, 0, 32'h6, 1'b0);
        checkOutput("tx_low_in_start", 32'(uart_tx), 32'd0);

        // Mid-frame reset with a transfer presented on the reset cycle
        @(negedge clk);
        rst = 1'b1; ss = 1'b1; bstart = 1'b1; bwrite = 1'b0;
        addr = 32'h1000_0008; tsize = SZ_WORD;
        @(negedge clk);
        checkOutput("midrst_uart_tx", 32'(uart_tx), 32'd1);
        checkOutput("midrst_bdone", 32'(bdone), 32'd0);
        rst = 1'b0; ss = 1'b0; bstart = 1'b0;
        @(negedge clk);
        checkOutput("midrst_no_late_bdone", 32'(bdone), 32'd0);
        busCheck("status_after_midrst", 1'b0, 32'h1000_0008, SZ_WORD, 0, 32'h1, 1'b0);
        busCheck("div_after_midrst", 1'b0, 32'h1000_000C, SZ_WORD, 0, 32'd868, 1'b0);

        // Loopback single frame 8'h3C at divisor 16
        loopback = 1'b1;
        busCheck("div_wr_16", 1'b1, 32'h1000_000C, SZ_WORD, 32'd16, 32'h0, 1'b0);
        busCheck("tx_push_3c", 1'b1, 32'h1000_0000, SZ_BYTE, 32'h3C, 32'h0, 1'b0);
        repeat (200) @(negedge clk);
        busCheck("status_rx_valid", 1'b0, 32'h1000_0008, SZ_WORD, 0, 32'h9, 1'b0);
        busCheck("rxdata_3c", 1'b0, 32'h1000_0004, SZ_WORD, 0, 32'h3C, 1'b0);
        busCheck("status_rx_cleared", 1'b0, 32'h1000_0008, SZ_WORD, 0, 32'h1, 1'b0);

        // Two frames without a read in between -> overrun
        busCheck("tx_push_11", 1'b1, 32'h1000_0000, SZ_BYTE, 32'h11, 32'h0, 1'b0);
        busCheck("tx_push_22", 1'b1, 32'h1000_0000, SZ_BYTE, 32'h22, 32'h0, 1'b0);
        repeat (380) @(negedge clk);
        busCheck("status_overrun", 1'b0, 32'h1000_0008, SZ_WORD, 0, 32'h19, 1'b0);
        busCheck("rxdata_22", 1'b0, 32'h1000_0004, SZ_WORD, 0, 32'h22, 1'b0);
        busCheck("status_overrun_clr", 1'b0, 32'h1000_0008, SZ_WORD, 0, 32'h1, 1'b0);
        loopback = 1'b0;

        // Error decode: no state change, rdata=0
        busCheck("err_rd_0x10", 1'b0, 32'h1000_0010, SZ_WORD, 0, 32'h0, 1'b1);
        busCheck("err_wr_status", 1'b1, 32'h1000_0008, SZ_WORD, 32'hFF, 32'h0, 1'b1);
        busCheck("err_byte_rd_div", 1'b0, 32'h1000_000C, SZ_BYTE, 0, 32'h0, 1'b1);
        busCheck("err_half_wr_div", 1'b1, 32'h1000_000C, SZ_HALF, 32'd5, 32'h0, 1'b1);
        busCheck("err_misaligned", 1'b0, 32'h1000_0006, SZ_WORD, 0, 32'h0, 1'b1);
        busCheck("err_wr_rxdata", 1'b1, 32'h1000_0004, SZ_WORD, 32'h55, 32'h0, 1'b1);
        busCheck("div_unchanged", 1'b0, 32'h1000_000C, SZ_WORD, 0, 32'd16, 1'b0);
        busCheck("status_unchanged", 1'b0, 32'h1000_0008, SZ_WORD, 0, 32'h1, 1'b0);

        // bstart without slave select is ignored
        @(negedge clk);
        ss = 1'b0; bstart = 1'b1; bwrite = 1'b0; addr = 32'h1000_0008;
        @(negedge clk);
        checkOutput("no_ss_no_bdone", 32'(bdone), 32'd0);
        bstart = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
